// File: rtl/preamble_tx_gen.sv
// Preamble transmitter: replays a half-symbol from a registered ROM as [A A] or [A -A] training
// symbols, repeated R times with zero-filled guard gaps, through a two-stage tagged pipeline.
module preamble_tx_gen #(
  parameter int WIDTH        = 10,
  parameter int HALF_LEN     = 64,
  parameter int ADDR_WIDTH   = 8,
  parameter int REPEAT_WIDTH = 4,
  parameter int GAP_WIDTH    = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    i_start,
  input  logic                    i_abort,
  input  logic                    i_mode,
  input  logic [REPEAT_WIDTH-1:0] i_repeat,
  input  logic [GAP_WIDTH-1:0]    i_gap,
  output logic [ADDR_WIDTH-1:0]   o_rom_addr,
  input  logic [WIDTH-1:0]        i_rom_data,
  output logic [WIDTH-1:0]        o_data,
  output logic                    o_valid,
  output logic                    o_busy,
  output logic                    o_end
);

  typedef enum logic [2:0] {IDLE, HALF0, HALF1, GAP, DRAIN} state_t;

  typedef struct packed {
    logic valid;
    logic neg;
    logic zero;
    logic last;
  } tag_t;

  localparam logic [ADDR_WIDTH-1:0] C_LAST = ADDR_WIDTH'(HALF_LEN - 1);
  localparam logic [WIDTH-1:0]      C_MIN  = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0]      C_MAX  = {1'b0, {(WIDTH-1){1'b1}}};

  state_t                  r_state;
  state_t                  w_next_state;
  logic [ADDR_WIDTH-1:0]   r_cnt;
  logic [REPEAT_WIDTH-1:0] r_sym;
  logic [REPEAT_WIDTH-1:0] r_rep_m1;
  logic [GAP_WIDTH-1:0]    r_gcnt;
  logic [GAP_WIDTH-1:0]    r_gap_len;
  logic                    r_mode;
  tag_t                    r_s1;
  tag_t                    w_slot;
  logic [WIDTH-1:0]        w_sample;

  logic w_half_done;
  logic w_last_sym;
  logic w_gap_done;

  assign w_half_done = (r_cnt == C_LAST);
  assign w_last_sym  = (r_sym == r_rep_m1);
  assign w_gap_done  = (r_gcnt == (r_gap_len - GAP_WIDTH'(1)));

  // NOTE: sequential state is written with <= so every register updates from pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next_state;
  end

  // NOTE: next state defaults to the current state first, so no path can infer a latch.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:  if (i_start) w_next_state = HALF0;
      HALF0: if (w_half_done) w_next_state = HALF1;
      HALF1: begin
        if (w_half_done) begin
          if (w_last_sym)                 w_next_state = DRAIN;
          else if (r_gap_len != '0)       w_next_state = GAP;
          else                            w_next_state = HALF0;
        end
      end
      GAP:   if (w_gap_done) w_next_state = HALF0;
      DRAIN: if (!r_s1.valid) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
    if (i_abort) w_next_state = IDLE;
  end

  always_comb begin
    o_rom_addr   = '0;
    o_busy       = (r_state != IDLE);
    w_slot       = '0;
    case (r_state)
      HALF0: begin
        o_rom_addr   = r_cnt;
        w_slot.valid = 1'b1;
      end
      HALF1: begin
        o_rom_addr   = r_cnt;
        w_slot.valid = 1'b1;
        w_slot.neg   = r_mode;
        w_slot.last  = w_half_done & w_last_sym;
      end
      GAP: begin
        w_slot.valid = 1'b1;
        w_slot.zero  = 1'b1;
      end
      default: ;
    endcase
  end

  // Configuration is captured only on an accepted start; counters restart from zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt     <= '0;
      r_sym     <= '0;
      r_gcnt    <= '0;
      r_mode    <= 1'b0;
      r_rep_m1  <= '0;
      r_gap_len <= '0;
    end else if (i_abort) begin
      r_cnt  <= '0;
      r_sym  <= '0;
      r_gcnt <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_start) begin
            r_mode    <= i_mode;
            r_rep_m1  <= (i_repeat == '0) ? '0 : (i_repeat - REPEAT_WIDTH'(1));
            r_gap_len <= i_gap;
            r_cnt     <= '0;
            r_sym     <= '0;
            r_gcnt    <= '0;
          end
        end
        HALF0: r_cnt <= w_half_done ? '0 : (r_cnt + ADDR_WIDTH'(1));
        HALF1: begin
          r_cnt <= w_half_done ? '0 : (r_cnt + ADDR_WIDTH'(1));
          if (w_half_done) r_sym <= r_sym + REPEAT_WIDTH'(1);
        end
        GAP:   r_gcnt <= w_gap_done ? '0 : (r_gcnt + GAP_WIDTH'(1));
        default: ;
      endcase
    end
  end

  // The most negative code has no positive twin, so it saturates to the largest positive code.
  always_comb begin
    w_sample = i_rom_data;
    if (r_s1.zero)                   w_sample = '0;
    else if (r_s1.neg && i_rom_data == C_MIN) w_sample = C_MAX;
    else if (r_s1.neg)               w_sample = (~i_rom_data) + WIDTH'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1    <= '0;
      o_data  <= '0;
      o_valid <= 1'b0;
      o_end   <= 1'b0;
    end else if (i_abort) begin
      r_s1    <= '0;
      o_valid <= 1'b0;
      o_end   <= 1'b0;
    end else begin
      r_s1    <= w_slot;
      o_valid <= r_s1.valid;
      o_end   <= r_s1.valid & r_s1.last;
      if (r_s1.valid) o_data <= w_sample;
    end
  end

endmodule

// File: tb/tb_preamble_tx_gen.sv
// Directed bench for preamble_tx_gen: registered ROM model, expected sample streams built
// from the ROM contents, immediate-assertion checks and a single result line.
module tb_preamble_tx_gen;

  logic       clk = 1'b0;
  logic       reset;
  logic       i_start;
  logic       i_abort;
  logic       i_mode;
  logic [3:0] i_repeat;
  logic [7:0] i_gap;
  logic [7:0] o_rom_addr;
  logic [9:0] i_rom_data;
  logic [9:0] o_data;
  logic       o_valid;
  logic       o_busy;
  logic       o_end;

  logic [9:0] rom [64];
  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  always @(posedge clk) i_rom_data <= rom[o_rom_addr[5:0]];

  preamble_tx_gen dut (
    .clk        (clk),
    .reset      (reset),
    .i_start    (i_start),
    .i_abort    (i_abort),
    .i_mode     (i_mode),
    .i_repeat   (i_repeat),
    .i_gap      (i_gap),
    .o_rom_addr (o_rom_addr),
    .i_rom_data (i_rom_data),
    .o_data     (o_data),
    .o_valid    (o_valid),
    .o_busy     (o_busy),
    .o_end      (o_end)
  );

  task automatic step();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int rom_val(input int a);
    logic signed [9:0] v;
    v = rom[a];
    return int'(v);
  endfunction

  function automatic int sat_neg(input int x);
    return (x == -512) ? 511 : -x;
  endfunction

  // Starts a transmission from the current (idle) cycle and checks the whole output stream.
  // glitch_at >= 1 pulses i_start with a different configuration after that many valid samples.
  task automatic run_check(input string name, input logic mode, input int rep, input int gap,
                           input int glitch_at);
    int   r_eff;
    int   exp_q[$];
    int   got_q[$];
    int   ends;
    int   end_idx;
    int   first_c;
    logic busy_at_end;
    r_eff = (rep == 0) ? 1 : rep;
    for (int s = 0; s < r_eff; s++) begin
      for (int a = 0; a < 64; a++) exp_q.push_back(rom_val(a));
      for (int a = 0; a < 64; a++) exp_q.push_back(mode ? sat_neg(rom_val(a)) : rom_val(a));
      if (s < r_eff - 1) for (int g = 0; g < gap; g++) exp_q.push_back(0);
    end
    ends = 0; end_idx = -1; first_c = -1; busy_at_end = 1'b0;

    i_start = 1'b1; i_mode = mode; i_repeat = 4'(rep); i_gap = 8'(gap);
    step();
    i_start = 1'b0; i_mode = ~mode; i_repeat = 4'd9; i_gap = 8'd7;
    check({name, ":busy_after_start"}, o_busy, 1);
    check({name, ":addr_after_start"}, o_rom_addr, 0);
    check({name, ":valid_edge0"}, o_valid, 0);
    step();
    check({name, ":valid_edge1"}, o_valid, 0);

    for (int c = 0; c < 3000; c++) begin
      step();
      i_start = 1'b0;
      if (o_valid) begin
        if (got_q.size() == 0) first_c = c;
        got_q.push_back(int'($signed(o_data)));
        if (o_end) begin
          ends++;
          end_idx     = got_q.size();
          busy_at_end = o_busy;
        end
        if (got_q.size() == glitch_at) i_start = 1'b1;
      end else if (got_q.size() > 0) begin
        break;
      end
    end
    i_start = 1'b0;

    check({name, ":first_valid_latency"}, first_c, 0);
    check({name, ":valid_count"}, got_q.size(), exp_q.size());
    check({name, ":end_count"}, ends, 1);
    check({name, ":end_position"}, end_idx, exp_q.size());
    check({name, ":busy_at_end"}, busy_at_end, 1);
    check({name, ":busy_after_end"}, o_busy, 0);
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check($sformatf("%s:sample%0d", name, i + 1), got_q[i], exp_q[i]);
  endtask

  // Starts [A A] R=1 and returns once the n-th valid sample is on the outputs.
  task automatic start_and_wait(input string name, input int n);
    int cnt;
    cnt = 0;
    i_start = 1'b1; i_mode = 1'b0; i_repeat = 4'd1; i_gap = 8'd0;
    step();
    i_start = 1'b0;
    for (int c = 0; c < 300; c++) begin
      step();
      if (o_valid) cnt++;
      if (cnt == n) break;
    end
    check({name, ":reached_sample"}, cnt, n);
  endtask

  initial begin
    int stray;
    reset = 1'b1; i_start = 1'b0; i_abort = 1'b0; i_mode = 1'b0;
    i_repeat = 4'd0; i_gap = 8'd0;
    for (int a = 0; a < 64; a++) rom[a] = 10'(a);
    repeat (3) step();
    check("reset:o_data", o_data, 0);
    check("reset:o_valid", o_valid, 0);
    check("reset:o_busy", o_busy, 0);
    check("reset:o_end", o_end, 0);
    check("reset:o_rom_addr", o_rom_addr, 0);
    reset = 1'b0;
    step();

    // Abort and start together in IDLE must leave the block idle.
    i_start = 1'b1; i_abort = 1'b1; i_repeat = 4'd1;
    step();
    i_start = 1'b0; i_abort = 1'b0;
    check("abort_start:busy", o_busy, 0);
    step(); step();
    check("abort_start:valid", o_valid, 0);

    run_check("aa_r1", 1'b0, 1, 0, -1);
    run_check("aneg_r1", 1'b1, 1, 0, -1);
    run_check("aa_r3_g5", 1'b0, 3, 5, -1);

    rom[0] = 10'h200;
    run_check("saturate", 1'b1, 1, 0, -1);
    rom[0] = 10'd0;

    start_and_wait("abort", 40);
    i_abort = 1'b1;
    step();
    i_abort = 1'b0;
    check("abort:o_valid", o_valid, 0);
    check("abort:o_busy", o_busy, 0);
    check("abort:o_end", o_end, 0);
    stray = 0;
    repeat (4) begin
      step();
      stray += int'(o_valid) + int'(o_end);
    end
    check("abort:no_stray_slots", stray, 0);
    run_check("after_abort", 1'b0, 2, 3, -1);

    run_check("repeat0", 1'b1, 0, 4, -1);
    run_check("start_glitch", 1'b0, 2, 2, 50);

    start_and_wait("mid_reset", 70);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("mid_reset:o_data", o_data, 0);
    check("mid_reset:o_valid", o_valid, 0);
    check("mid_reset:o_busy", o_busy, 0);
    check("mid_reset:o_end", o_end, 0);
    check("mid_reset:o_rom_addr", o_rom_addr, 0);
    step();
    run_check("post_reset", 1'b1, 1, 0, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
